sc_sidecomparator_bounce: RTL

// - Parametrised edge detector plus direction controller for the one-hot shift-register display path.
// - Samples the shifter bus on each step strobe and flags when the lit bit reaches the right edge (bit 0) or the left edge (bit W-1).
// - Runs a bounce FSM that tells the shifter which way to move, and stalls it for a programmable number of steps at each edge.
// - Counts direction reversals for the score/status logic.

---
 rtl/sc_sidecomparator_bounce.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sc_sidecomparator_bounce.sv
// sc_sidecomparator_bounce
// Edge detector and bounce direction controller for the one-hot shifter display.
// The shifter bus is sampled on each enable strobe. The block pulses when the lit
// bit reaches either edge and holds at an edge for HOLD_STEPS enables before it
// reverses direction. Direction reversals are counted.
// Optional build macro: SC_SIDECOMPARATORBOUNCE_WRAP_EN. When defined, the
// reversal counter wraps to 0. When undefined, it saturates at all-ones.
module sc_sidecomparator_bounce #(
    parameter int DATAWIDTH  = 8,
    parameter int HOLD_STEPS = 2,
    parameter int HITWIDTH   = 4
) (
    input  logic                 SC_SIDECOMPARATORBOUNCE_CLOCK_50,
    input  logic                 SC_SIDECOMPARATORBOUNCE_RESET_InHigh,
    input  logic [DATAWIDTH-1:0] SC_SIDECOMPARATORBOUNCE_data_InBUS,
    input  logic                 SC_SIDECOMPARATORBOUNCE_enable_InHigh,
    input  logic                 SC_SIDECOMPARATORBOUNCE_clear_InHigh,
    output logic                 SC_SIDECOMPARATORBOUNCE_rightside_OutHigh,
    output logic                 SC_SIDECOMPARATORBOUNCE_leftside_OutHigh,
    output logic                 SC_SIDECOMPARATORBOUNCE_direction_Out,
    output logic                 SC_SIDECOMPARATORBOUNCE_stall_OutHigh,
    output logic [HITWIDTH-1:0]  SC_SIDECOMPARATORBOUNCE_hitcount_OutBUS,
    output logic                 SC_SIDECOMPARATORBOUNCE_invalid_OutHigh
);

    localparam int HOLDW = (HOLD_STEPS < 2) ? 1 : $clog2(HOLD_STEPS + 1);
    localparam logic [HOLDW-1:0]     HOLD_LOAD = HOLDW'(HOLD_STEPS);
    localparam logic [DATAWIDTH-1:0] RIGHT_PAT = DATAWIDTH'(1);
    localparam logic [DATAWIDTH-1:0] LEFT_PAT  = RIGHT_PAT << (DATAWIDTH - 1);

    typedef enum logic [1:0] {
        MOVE_R,
        HOLD_R,
        MOVE_L,
        HOLD_L
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic [HOLDW-1:0]     hold;
    logic [HOLDW-1:0]     holdNext;
    logic [HITWIDTH-1:0]  hitCount;
    logic [HITWIDTH-1:0]  hitCountNext;
    logic                 countInc;
    logic                 rightPulse;
    logic                 leftPulse;
    logic                 invalidReg;

    logic                 enable;
    logic                 rightMatch;
    logic                 leftMatch;
    logic                 validSample;

    assign enable      = SC_SIDECOMPARATORBOUNCE_enable_InHigh;
    assign rightMatch  = enable && (SC_SIDECOMPARATORBOUNCE_data_InBUS == RIGHT_PAT);
    assign leftMatch   = enable && (SC_SIDECOMPARATORBOUNCE_data_InBUS == LEFT_PAT);
    assign validSample = enable && $onehot(SC_SIDECOMPARATORBOUNCE_data_InBUS);

    // State, hold counter and reversal counter registers
    always_ff @(posedge SC_SIDECOMPARATORBOUNCE_CLOCK_50 or posedge SC_SIDECOMPARATORBOUNCE_RESET_InHigh) begin
        if (SC_SIDECOMPARATORBOUNCE_RESET_InHigh) begin
            state    <= MOVE_R;
            hold     <= '0;
            hitCount <= '0;
        end else begin
            state    <= stateNext;
            hold     <= holdNext;
            hitCount <= hitCountNext;
        end
    end

    // Registered edge pulses and invalid flag, refreshed only on enabled samples
    always_ff @(posedge SC_SIDECOMPARATORBOUNCE_CLOCK_50 or posedge SC_SIDECOMPARATORBOUNCE_RESET_InHigh) begin
        if (SC_SIDECOMPARATORBOUNCE_RESET_InHigh) begin
            rightPulse <= 1'b0;
            leftPulse  <= 1'b0;
            invalidReg <= 1'b0;
        end else begin
            rightPulse <= rightMatch;
            leftPulse  <= leftMatch;
            if (enable) begin
                invalidReg <= !validSample;
            end
        end
    end

    // Bounce FSM next-state, hold countdown and reversal counter update
    always_comb begin
        stateNext    = state;
        holdNext     = hold;
        countInc     = 1'b0;
        hitCountNext = hitCount;

        case (state)
            MOVE_R: begin
                if (validSample && rightMatch) begin
                    countInc = 1'b1;
                    if (HOLD_STEPS == 0) begin
                        stateNext = MOVE_L;
                    end else begin
                        stateNext = HOLD_R;
                        holdNext  = HOLD_LOAD;
                    end
                end
            end
            HOLD_R: begin
                if (validSample) begin
                    if (hold == HOLDW'(1)) begin
                        stateNext = MOVE_L;
                        holdNext  = '0;
                    end else begin
                        holdNext = hold - 1'b1;
                    end
                end
            end
            MOVE_L: begin
                if (validSample && leftMatch) begin
                    countInc = 1'b1;
                    if (HOLD_STEPS == 0) begin
                        stateNext = MOVE_R;
                    end else begin
                        stateNext = HOLD_L;
                        holdNext  = HOLD_LOAD;
                    end
                end
            end
            HOLD_L: begin
                if (validSample) begin
                    if (hold == HOLDW'(1)) begin
                        stateNext = MOVE_R;
                        holdNext  = '0;
                    end else begin
                        holdNext = hold - 1'b1;
                    end
                end
            end
            default: begin
                stateNext = MOVE_R;
                holdNext  = '0;
            end
        endcase

        if (SC_SIDECOMPARATORBOUNCE_clear_InHigh) begin
            hitCountNext = '0;
        end else if (countInc) begin
`ifdef SC_SIDECOMPARATORBOUNCE_WRAP_EN
            hitCountNext = hitCount + 1'b1;
`else
            if (hitCount != '1) begin
                hitCountNext = hitCount + 1'b1;
            end
`endif
        end
    end

    assign SC_SIDECOMPARATORBOUNCE_rightside_OutHigh = rightPulse;
    assign SC_SIDECOMPARATORBOUNCE_leftside_OutHigh  = leftPulse;
    assign SC_SIDECOMPARATORBOUNCE_direction_Out     = (state == MOVE_L) || (state == HOLD_L);
    assign SC_SIDECOMPARATORBOUNCE_stall_OutHigh     = (state == HOLD_R) || (state == HOLD_L);
    assign SC_SIDECOMPARATORBOUNCE_hitcount_OutBUS   = hitCount;
    assign SC_SIDECOMPARATORBOUNCE_invalid_OutHigh   = invalidReg;

endmodule
